// File: rtl/ram_scan_ctrl.sv
// RAM scan controller: inferred DEPTH x DATA_W RAM walked by an auto (prescaled)
// or manual (push-button) address sequencer, with a zero-fill clear sweep.
module ram_scan_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int TICK_DIV = 50000000
) (
    input  logic              CLOCK_50,
    input  logic              KEY,
    input  logic [1:0]        mode,
    input  logic              step,
    input  logic              hold,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdata,
    output logic              tick,
    output logic              busy,
    output logic              done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_MAN  = 2'b10;
    localparam logic [1:0] MODE_CLR  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                tick_q, tick_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          sync_q, sync_d;

    logic                step_evt;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    // State register plus all resettable datapath flops.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            rdata_q <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
        end
    end

    // RAM contents survive reset so a partially cleared array stays as is.
    always_ff @(posedge CLOCK_50) begin
        if (ram_we) begin
            mem[addr_q] <= ram_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (mode == MODE_CLR) state_d = ST_CLEAR;
            ST_CLEAR: if (addr_q == ADDR_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_WAIT;
            ST_WAIT:  if (mode != MODE_CLR) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Datapath: prescaler, step detection, address sequencing, RAM port.
    always_comb begin
        cnt_d     = '0;
        sync_d    = {sync_q[1:0], step};
        step_evt  = 1'b0;
        addr_d    = addr_q;
        ram_we    = 1'b0;
        ram_wdata = wdata;

        case (state_q)
            ST_RUN: begin
                case (mode)
                    MODE_UP, MODE_DOWN: begin
                        if (hold) begin
                            cnt_d = cnt_q;
                        end else if (cnt_q == CNT_MAX) begin
                            step_evt = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    MODE_MAN: step_evt = sync_q[1] & ~sync_q[2] & ~hold;
                    default:  addr_d = '0;
                endcase
                if (step_evt) begin
                    ram_we = wr_en;
                    addr_d = (mode == MODE_DOWN) ? addr_q - ADDR_W'(1)
                                                 : addr_q + ADDR_W'(1);
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_wdata = '0;
                addr_d    = addr_q + ADDR_W'(1);
            end
            default: addr_d = '0;
        endcase

        tick_d  = step_evt;
        // Write-first: a same-cycle write to the read address is forwarded.
        rdata_d = ram_we ? ram_wdata : mem[addr_q];
    end

    // Outputs.
    always_comb begin
        busy  = (state_q == ST_CLEAR);
        done  = (state_q == ST_DONE);
        addr  = addr_q;
        rdata = rdata_q;
        tick  = tick_q;
    end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Bench for ram_scan_ctrl with TICK_DIV=4: auto/manual stepping, hold, write-first,
// clear sweep and reset during a clear.
module tb_ram_scan_ctrl;

    logic       clk;
    logic       key;
    logic [1:0] mode;
    logic       step;
    logic       hold;
    logic       wr_en;
    logic [7:0] wdata;
    logic [4:0] addr;
    logic [7:0] rdata;
    logic       tick;
    logic       busy;
    logic       done;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic [7:0] model_mem[32];
    logic [4:0] exp_addr;
    logic [7:0] exp_v;

    ram_scan_ctrl #(
        .DATA_W  (8),
        .ADDR_W  (5),
        .TICK_DIV(4)
    ) dut (
        .CLOCK_50(clk),
        .KEY     (key),
        .mode    (mode),
        .step    (step),
        .hold    (hold),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .addr    (addr),
        .rdata   (rdata),
        .tick    (tick),
        .busy    (busy),
        .done    (done)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        key   = 1'b0;
        mode  = m;
        step  = 1'b0;
        hold  = 1'b0;
        wr_en = 1'b0;
        wdata = 8'h00;
        @(posedge clk);
        #1;
        key      = 1'b1;
        exp_addr = 5'd0;
    endtask

    // Driver: one manual step; optional write at the old address, optional readback of the new one.
    task automatic manual_step(input logic we, input logic [7:0] d, input logic rd);
        logic [4:0] na;
        na    = exp_addr + 5'd1;
        wr_en = we;
        wdata = d;
        step  = 1'b1;
        if (we) begin
            exp_q.push_back(d);
            model_mem[exp_addr] = d;
        end
        cyc();
        cyc();
        checks++;
        if (addr !== exp_addr) begin
            errors++;
            $display("FAIL man_early addr got %0d expected %0d", addr, exp_addr);
        end
        step = 1'b0;
        cyc();
        checks++;
        if (addr !== na || tick !== 1'b1) begin
            errors++;
            $display("FAIL man_step addr/tick got %0d/%0b expected %0d/1", addr, tick, na);
        end
        if (we) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rdata !== exp_v) begin
                errors++;
                $display("FAIL write_first rdata got %0h expected %0h", rdata, exp_v);
            end
        end
        exp_addr = na;
        wr_en    = 1'b0;
        if (rd) exp_q.push_back(model_mem[na]);
        cyc();
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL man_tick_width got %0b expected 0", tick);
        end
        if (rd) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rdata !== exp_v) begin
                errors++;
                $display("FAIL readback addr %0d rdata got %0h expected %0h", na, rdata, exp_v);
            end
        end
        cyc();
    endtask

    task automatic test_reset();
        key   = 1'b0;
        mode  = 2'b00;
        step  = 1'b0;
        hold  = 1'b0;
        wr_en = 1'b0;
        wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({addr, rdata, tick, busy, done} !== 16'h0000) begin
            errors++;
            $display("FAIL reset addr=%0h rdata=%0h tick=%0b busy=%0b done=%0b expected all 0",
                     addr, rdata, tick, busy, done);
        end
    endtask

    task automatic test_auto_up();
        logic [4:0] ea;
        do_reset(2'b00);
        for (int k = 1; k <= 132; k++) begin
            cyc();
            ea = 5'((k / 4) % 32);
            checks++;
            if (addr !== ea || tick !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL auto_up cycle %0d addr/tick got %0d/%0b expected %0d/%0b",
                         k, addr, tick, ea, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_auto_down_hold();
        logic [4:0] ea;
        do_reset(2'b01);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            ea = (k < 4) ? 5'd0 : (k < 8) ? 5'd31 : 5'd30;
            checks++;
            if (addr !== ea || tick !== (k == 4 || k == 8)) begin
                errors++;
                $display("FAIL auto_down cycle %0d addr/tick got %0d/%0b expected %0d", k, addr, tick, ea);
            end
        end
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            checks++;
            if (addr !== 5'd30 || tick !== 1'b0) begin
                errors++;
                $display("FAIL hold addr/tick got %0d/%0b expected 30/0", addr, tick);
            end
        end
        hold = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++;
            if (addr !== 5'd30) begin
                errors++;
                $display("FAIL hold_resume_early addr got %0d expected 30", addr);
            end
        end
        cyc();
        checks++;
        if (addr !== 5'd29 || tick !== 1'b1) begin
            errors++;
            $display("FAIL hold_resume addr/tick got %0d/%0b expected 29/1", addr, tick);
        end
    endtask

    task automatic test_manual_write();
        do_reset(2'b10);
        wr_en = 1'b1;
        wdata = 8'hA5;
        step  = 1'b1;
        exp_q.push_back(8'hA5);
        model_mem[0] = 8'hA5;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            checks++;
            if (addr !== ((k >= 3) ? 5'd1 : 5'd0) || tick !== (k == 3)) begin
                errors++;
                $display("FAIL manual_long cycle %0d addr/tick got %0d/%0b", k, addr, tick);
            end
            if (k == 3) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (rdata !== exp_v) begin
                    errors++;
                    $display("FAIL manual_wr rdata got %0h expected %0h", rdata, exp_v);
                end
            end
        end
        step  = 1'b0;
        wr_en = 1'b0;
        mode  = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if (addr !== ((k < 4) ? 5'd1 : 5'd0)) begin
                errors++;
                $display("FAIL return_addr cycle %0d addr got %0d", k, addr);
            end
        end
        mode = 2'b10;
        exp_q.push_back(model_mem[0]);
        cyc();
        exp_v = exp_q.pop_front();
        checks++;
        if (rdata !== exp_v) begin
            errors++;
            $display("FAIL readback_a5 rdata got %0h expected %0h", rdata, exp_v);
        end
        exp_addr = 5'd0;
    endtask

    task automatic test_collision();
        for (int i = 0; i < 3; i++) manual_step(1'b0, 8'h00, 1'b0);
        manual_step(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) manual_step(1'b0, 8'h00, 1'b0);
        manual_step(1'b1, 8'h3C, 1'b0);
    endtask

    task automatic test_clear();
        mode = 2'b11;
        for (int a = 0; a < 32; a++) model_mem[a] = 8'h00;
        cyc();
        checks++;
        if (busy !== 1'b1 || addr !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_entry busy/addr/done got %0b/%0d/%0b expected 1/0/0", busy, addr, done);
        end
        for (int i = 1; i < 32; i++) begin
            cyc();
            checks++;
            if (busy !== 1'b1 || addr !== 5'(i) || tick !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL clear_sweep %0d busy/addr/tick/done got %0b/%0d/%0b/%0b",
                         i, busy, addr, tick, done);
            end
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || addr !== 5'd0) begin
            errors++;
            $display("FAIL clear_done busy/done/addr got %0b/%0b/%0d expected 0/1/0", busy, done, addr);
        end
        for (int i = 0; i < 50; i++) begin
            cyc();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || addr !== 5'd0) begin
                errors++;
                $display("FAIL clear_wait busy/done/addr got %0b/%0b/%0d expected 0/0/0", busy, done, addr);
            end
        end
        mode = 2'b10;
        cyc();
        cyc();
        exp_addr = 5'd0;
        exp_q.push_back(model_mem[0]);
        exp_v = exp_q.pop_front();
        checks++;
        if (rdata !== exp_v) begin
            errors++;
            $display("FAIL clear_read0 rdata got %0h expected %0h", rdata, exp_v);
        end
        for (int i = 0; i < 32; i++) manual_step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid_clear();
        for (int a = 0; a <= 20; a++) manual_step(1'b1, 8'h80 + 8'(a), 1'b0);
        mode = 2'b11;
        for (int i = 0; i < 11; i++) cyc();
        checks++;
        if (busy !== 1'b1 || addr !== 5'd10) begin
            errors++;
            $display("FAIL mid_clear busy/addr got %0b/%0d expected 1/10", busy, addr);
        end
        key = 1'b0;
        #2;
        checks++;
        if ({addr, rdata, tick, busy, done} !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset addr=%0h rdata=%0h tick=%0b busy=%0b done=%0b expected all 0",
                     addr, rdata, tick, busy, done);
        end
        mode = 2'b10;
        for (int a = 0; a < 10; a++) model_mem[a] = 8'h00;
        @(posedge clk);
        #1;
        key      = 1'b1;
        exp_addr = 5'd0;
        cyc();
        cyc();
        exp_q.push_back(model_mem[0]);
        exp_v = exp_q.pop_front();
        checks++;
        if (rdata !== exp_v || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_read0 rdata/busy got %0h/%0b expected %0h/0", rdata, busy, exp_v);
        end
        for (int i = 0; i < 20; i++) manual_step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_auto_up();
        test_auto_down_hold();
        test_manual_write();
        test_collision();
        test_clear();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
